// File: rtl/uart_cmd_deframer.sv
// UART command-frame deframer: store-and-forward buffer, speculative write pointer.
// Define UART_CMD_CRC8_EN to check frames with CRC-8 (poly 0x07) instead of XOR.
module uart_cmd_deframer #(
    parameter int unsigned BUF_DEPTH      = 64,
    parameter int unsigned MAX_PAYLOAD    = 32,
    parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
    parameter int unsigned TIMEOUT_CYCLES = 3200
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sof,
    output logic       out_eof,
    output logic       frame_ok,
    output logic       err_valid,
    output logic [2:0] err_code,
    output logic       busy
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_CMD, S_PAY, S_CHK, S_DISC
    } state_t;

    typedef enum logic [1:0] {R_CMD, R_NPL, R_PAY} rph_t;

    state_t        state_q;
    rph_t          rph_q;
    logic [PW-1:0] wr_q, cm_q, rd_q;
    logic [7:0]    chk_q, cnt_q, rrem_q;
    logic [31:0]   tmo_q;
    logic [7:0]    mem [BUF_DEPTH];

    logic [PW-1:0] used, free;
    logic [31:0]   len32;
    logic          len_bad, len_nofit, tmo_hit;
    logic          we;
    logic [AW-1:0] wa;
    logic [7:0]    wd, rbyte;

    function automatic logic [7:0] chk_upd(input logic [7:0] acc,
                                           input logic [7:0] b);
`ifdef UART_CMD_CRC8_EN
        logic [7:0] c;
        c = acc ^ b;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
`else
        return acc ^ b;
`endif
    endfunction

    assign used      = wr_q - rd_q;
    assign free      = PW'(BUF_DEPTH) - used;
    assign len32     = {24'd0, rx_data};
    assign len_bad   = (len32 < 32'd2) || (len32 > MAX_PAYLOAD + 32'd2);
    assign len_nofit = free < PW'(rx_data);
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && !rx_valid &&
                       (state_q != S_IDLE) &&
                       (tmo_q == TIMEOUT_CYCLES - 32'd1);
    assign busy      = (state_q != S_IDLE);
    assign rbyte     = mem[rd_q[AW-1:0]];

    // NPL goes one slot past CMD so the reader sees CMD first
    always_comb begin
        we = 1'b0;
        wa = wr_q[AW-1:0];
        wd = rx_data;
        if (rx_valid && !tmo_hit) begin
            case (state_q)
                S_LEN: if (!len_bad && !len_nofit) begin
                    we = 1'b1;
                    wa = wr_q[AW-1:0] + AW'(1);
                    wd = rx_data - 8'd2;
                end
                S_CMD, S_PAY: we = 1'b1;
                default: we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (we)
            mem[wa] <= wd;
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wr_q      <= '0;
            cm_q      <= '0;
            chk_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            frame_ok  <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= '0;
        end else begin
            frame_ok  <= 1'b0;
            err_valid <= 1'b0;
            if (rx_valid || state_q == S_IDLE)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + 32'd1;
            if (tmo_hit) begin
                wr_q      <= cm_q;
                err_valid <= 1'b1;
                err_code  <= 3'd4;
                state_q   <= S_IDLE;
            end else if (rx_valid) begin
                case (state_q)
                    S_IDLE: if (rx_data == SYNC_BYTE) begin
                        chk_q   <= 8'h00;
                        state_q <= S_LEN;
                    end
                    S_LEN: begin
                        if (len_bad) begin
                            err_valid <= 1'b1;
                            err_code  <= 3'd2;
                            state_q   <= S_IDLE;
                        end else if (len_nofit) begin
                            err_valid <= 1'b1;
                            err_code  <= 3'd3;
                            cnt_q     <= rx_data;
                            state_q   <= S_DISC;
                        end else begin
                            chk_q   <= chk_upd(8'h00, rx_data);
                            cnt_q   <= rx_data - 8'd2;
                            state_q <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        chk_q   <= chk_upd(chk_q, rx_data);
                        wr_q    <= wr_q + PW'(2);
                        state_q <= (cnt_q == 8'd0) ? S_CHK : S_PAY;
                    end
                    S_PAY: begin
                        chk_q <= chk_upd(chk_q, rx_data);
                        wr_q  <= wr_q + PW'(1);
                        cnt_q <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1)
                            state_q <= S_CHK;
                    end
                    S_CHK: begin
                        if (rx_data == chk_q) begin
                            cm_q     <= wr_q;
                            frame_ok <= 1'b1;
                        end else begin
                            wr_q      <= cm_q;
                            err_valid <= 1'b1;
                            err_code  <= 3'd1;
                        end
                        state_q <= S_IDLE;
                    end
                    S_DISC: begin
                        cnt_q <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1)
                            state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Output register refills whenever empty or consumed; rd stops at commit
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            rd_q      <= '0;
            rph_q     <= R_CMD;
            rrem_q    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (rd_q != cm_q) begin
                rd_q      <= rd_q + PW'(1);
                out_valid <= 1'b1;
                out_data  <= rbyte;
                out_sof   <= (rph_q == R_CMD);
                case (rph_q)
                    R_CMD: begin
                        out_eof <= 1'b0;
                        rph_q   <= R_NPL;
                    end
                    R_NPL: begin
                        out_eof <= (rbyte == 8'd0);
                        rrem_q  <= rbyte;
                        rph_q   <= (rbyte == 8'd0) ? R_CMD : R_PAY;
                    end
                    default: begin
                        out_eof <= (rrem_q == 8'd1);
                        rrem_q  <= rrem_q - 8'd1;
                        if (rrem_q == 8'd1)
                            rph_q <= R_CMD;
                    end
                endcase
            end else begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
                out_eof   <= 1'b0;
            end
        end
    end
endmodule
